// File: rtl/ir_bcd_formatter.sv
//------------------------------------------------------------------------------
// Module      : ir_bcd_formatter
// Description : Converts accepted IR command / repeat / error strobes into a
//               prefixed 3-digit BCD word for the serial display driver.
//               Optional macro IR_RPT_COUNT_EN: show a saturating repeat count
//               instead of redisplaying the last command on repeat frames.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ir_bcd_formatter #(
   parameter logic [3:0] CMD_PREFIX = 4'd12,
   parameter logic [3:0] RPT_PREFIX = 4'd13,
   parameter logic [3:0] ERR_PREFIX = 4'd15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  cmd,
   input  logic        cmd_valid,
   input  logic        rpt_valid,
   input  logic        err_valid,
   output logic        busy,
   output logic [15:0] bcd_data,
   output logic        bcd_update
);

   localparam logic [1:0] c_IDLE      = 2'd0;
   localparam logic [1:0] c_CONV      = 2'd1;
   localparam logic [1:0] c_DONE      = 2'd2;
   localparam logic [2:0] c_LAST_ITER = 3'd7;

   logic [1:0]  r_state;
   logic [1:0]  w_next_state;
   logic [2:0]  r_iter;
   logic [19:0] r_shift;       // {bcd12, bin8} double-dabble working register
   logic [3:0]  r_prefix;
   logic [15:0] r_bcd_data;
   logic        r_bcd_update;
   logic        w_accept;
   logic [7:0]  w_sel_value;
   logic [3:0]  w_sel_prefix;
   logic [11:0] w_adj;
   logic [19:0] w_dd_next;

`ifdef IR_RPT_COUNT_EN
   logic [7:0]  r_rpt_cnt;
   logic [7:0]  w_rpt_inc;

   assign w_rpt_inc = (r_rpt_cnt == 8'hFF) ? 8'hFF : r_rpt_cnt + 8'd1;
`else
   logic [7:0]  r_last_cmd;
`endif

   // Strobes are only looked at in IDLE; anything arriving while busy is lost.
   assign w_accept = (r_state == c_IDLE) && (err_valid || cmd_valid || rpt_valid);

   always_comb begin
      w_sel_value  = 8'h00;
      w_sel_prefix = ERR_PREFIX;
      if (err_valid) begin
         w_sel_value  = 8'h00;
         w_sel_prefix = ERR_PREFIX;
      end else if (cmd_valid) begin
         w_sel_value  = cmd;
         w_sel_prefix = CMD_PREFIX;
      end else begin
`ifdef IR_RPT_COUNT_EN
         w_sel_value  = w_rpt_inc;
`else
         w_sel_value  = r_last_cmd;
`endif
         w_sel_prefix = RPT_PREFIX;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_dd_adj
         assign w_adj[gi*4 +: 4] = (r_shift[8+gi*4 +: 4] >= 4'd5)
                                 ? r_shift[8+gi*4 +: 4] + 4'd3
                                 : r_shift[8+gi*4 +: 4];
      end
   endgenerate

   assign w_dd_next = {w_adj, r_shift[7:0]} << 1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         c_IDLE:  if (w_accept) w_next_state = c_CONV;
         c_CONV:  if (r_iter == c_LAST_ITER) w_next_state = c_DONE;
         c_DONE:  w_next_state = c_IDLE;
         default: w_next_state = c_IDLE;
      endcase
   end

   always_comb begin
      busy = (r_state != c_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_iter       <= 3'd0;
         r_shift      <= 20'h0_0000;
         r_prefix     <= CMD_PREFIX;
         r_bcd_data   <= {CMD_PREFIX, 12'h000};
         r_bcd_update <= 1'b0;
`ifdef IR_RPT_COUNT_EN
         r_rpt_cnt    <= 8'h00;
`else
         r_last_cmd   <= 8'h00;
`endif
      end else begin
         r_bcd_update <= 1'b0;
         case (r_state)
            c_IDLE: begin
               if (w_accept) begin
                  r_shift  <= {12'h000, w_sel_value};
                  r_prefix <= w_sel_prefix;
                  r_iter   <= 3'd0;
`ifdef IR_RPT_COUNT_EN
                  if (!err_valid) begin
                     r_rpt_cnt <= cmd_valid ? 8'h00 : w_rpt_inc;
                  end
`else
                  if (!err_valid && cmd_valid) begin
                     r_last_cmd <= cmd;
                  end
`endif
               end
            end
            c_CONV: begin
               r_shift <= w_dd_next;
               r_iter  <= r_iter + 3'd1;
            end
            c_DONE: begin
               r_bcd_data   <= {r_prefix, r_shift[19:8]};
               r_bcd_update <= 1'b1;
            end
            default: begin
               r_iter <= 3'd0;
            end
         endcase
      end
   end

   assign bcd_data   = r_bcd_data;
   assign bcd_update = r_bcd_update;

endmodule

`default_nettype wire
